// File: rtl/obuf_pkg.sv
// Shared types and helpers for the skewing output buffer.
// Holds the drain FSM state enum and the diagonal-write lane mask.
package obuf_pkg;

    typedef enum logic {
        ST_IDLE,
        ST_DRAIN
    } state_t;

    // A diagonal write at row offset addr_mod within its block reaches
    // lanes 0..addr_mod; higher lanes would cross into the previous block.
    function automatic logic skew_lane_en(
        input int unsigned addr_mod,
        input int unsigned lane
    );
        return lane <= addr_mod;
    endfunction

endpackage

// File: rtl/output_buffer_skew_if.sv
// Downstream stream bundle of the output buffer.
// master drives M_DATA/M_VALID/M_LAST, slave drives M_READY.
interface output_buffer_skew_if #(
    parameter int W = 512
) ();
    logic [W-1:0] M_DATA;
    logic         M_VALID;
    logic         M_READY;
    logic         M_LAST;

    modport master (
        output M_DATA,
        output M_VALID,
        output M_LAST,
        input  M_READY
    );

    modport slave (
        input  M_DATA,
        input  M_VALID,
        input  M_LAST,
        output M_READY
    );
endinterface

// File: rtl/obuf_drain_ctrl.sv
// Drain engine: FSM, row pointer / remaining count and stream registers.
// Ports: CLK, RST, DRAIN_START/BASE/LEN, rd_data (row at ptr), ptr, BUSY, m.
module obuf_drain_ctrl
    import obuf_pkg::*;
#(
    parameter int W     = 512,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          DRAIN_START,
    input  logic [AW-1:0] DRAIN_BASE,
    input  logic [AW:0]   DRAIN_LEN,
    input  logic [W-1:0]  rd_data,
    output logic [AW-1:0] ptr,
    output logic          BUSY,
    output_buffer_skew_if.master m
);
    state_t        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW:0]   rem_q, rem_d;
    logic [W-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          last_q, last_d;
    logic          busy_q, busy_d;
    logic          adv;

    // The output slot is free when empty or being consumed this cycle.
    assign adv = !valid_q || m.M_READY;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (DRAIN_START && DRAIN_LEN != '0) begin
                    state_d = ST_DRAIN;
                    ptr_d   = DRAIN_BASE;
                    rem_d   = DRAIN_LEN;
                    busy_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (adv && rem_q != '0) begin
                    data_d  = rd_data;
                    valid_d = 1'b1;
                    last_d  = (rem_q == (AW+1)'(1));
                    ptr_d   = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
                    rem_d   = rem_q - 1'b1;
                end else if (adv) begin
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign ptr       = ptr_q;
    assign BUSY      = busy_q;
    assign m.M_DATA  = data_q;
    assign m.M_VALID = valid_q;
    assign m.M_LAST  = last_q;
endmodule

// File: rtl/output_buffer_skew.sv
// Result-path output buffer with direct or diagonal host writes and a drain
// stream. Ports: CLK, RST, host CEN/WEN/SKEW/A/D/Q/Q_VALID/ERR, drain
// DRAIN_START/BASE/LEN/BUSY, stream bundle m.
module output_buffer_skew
    import obuf_pkg::*;
#(
    parameter int LANES  = 16,
    parameter int LANE_W = 32,
    parameter int DEPTH  = 64,
    parameter int AW     = $clog2(DEPTH),
    parameter int W      = LANES * LANE_W
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CEN,
    input  logic          WEN,
    input  logic          SKEW,
    input  logic [AW-1:0] A,
    input  logic [W-1:0]  D,
    output logic [W-1:0]  Q,
    output logic          Q_VALID,
    input  logic          DRAIN_START,
    input  logic [AW-1:0] DRAIN_BASE,
    input  logic [AW:0]   DRAIN_LEN,
    output logic          BUSY,
    output logic          ERR,
    output_buffer_skew_if.master m
);
    localparam int LB = $clog2(LANES);

    logic [W-1:0]  host_rd;
    logic [W-1:0]  drain_rd;
    logic [AW-1:0] ptr;
    logic          wr_en;
    int unsigned   amod;

    assign wr_en = !CEN && !WEN && !BUSY;
    assign amod  = int'(A[LB-1:0]);

    // Each lane owns its own column so a diagonal write can hit a
    // different row in every lane within one cycle.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        logic [LANE_W-1:0] mem [DEPTH];
        logic [AW:0]       row_w;
        logic              skew_en;

        assign row_w   = {1'b0, A} - (AW+1)'(g);
        assign skew_en = skew_lane_en(amod, g) && !row_w[AW];

        always_ff @(posedge CLK) begin
            if (wr_en) begin
                if (!SKEW)
                    mem[A] <= D[g*LANE_W +: LANE_W];
                else if (skew_en)
                    mem[row_w[AW-1:0]] <= D[g*LANE_W +: LANE_W];
            end
        end

        assign host_rd[g*LANE_W +: LANE_W]  = mem[A];
        assign drain_rd[g*LANE_W +: LANE_W] = mem[ptr];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q       <= '0;
            Q_VALID <= 1'b0;
            ERR     <= 1'b0;
        end else begin
            Q       <= '0;
            Q_VALID <= 1'b0;
            ERR     <= 1'b0;
            if (!CEN) begin
                if (BUSY) begin
                    ERR <= 1'b1;
                end else if (WEN) begin
                    Q       <= host_rd;
                    Q_VALID <= 1'b1;
                end
            end
        end
    end

    obuf_drain_ctrl #(
        .W     (W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_drain (
        .CLK         (CLK),
        .RST         (RST),
        .DRAIN_START (DRAIN_START),
        .DRAIN_BASE  (DRAIN_BASE),
        .DRAIN_LEN   (DRAIN_LEN),
        .rd_data     (drain_rd),
        .ptr         (ptr),
        .BUSY        (BUSY),
        .m           (m)
    );
endmodule
